// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial add/sub FSM encoding and operation codes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// Start/busy/done handshake between the control unit (master) and the serial adder (slave).
interface serial_addsub_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, c_out, overflow, zero
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, c_out, overflow, zero
    );

endinterface

// File: rtl/serial_fa_cell.sv
// Single combinational 1-bit full adder, reused every cycle by the serial datapath.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per operation.
module serial_addsub
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    serial_addsub_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             c_out_r;
    logic             ovf_r;
    logic             zero_r;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic [WIDTH-1:0] next_res;

    serial_fa_cell u_fa (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign next_res = {fa_sum, res_sh[WIDTH-1:1]};

    // Subtraction is a + ~b + 1: invert B on load and seed the carry with op_sub.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        sh_a    <= bus.a;
                        sh_b    <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
                        carry   <= (bus.op_sub == OP_SUB);
                        cnt     <= '0;
                        res_sh  <= '0;
                        c_out_r <= 1'b0;
                        ovf_r   <= 1'b0;
                        zero_r  <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    res_sh <= next_res;
                    carry  <= fa_cout;
                    // On the MSB, carry still holds the carry into the MSB.
                    if (last_bit) begin
                        c_out_r <= fa_cout;
                        ovf_r   <= carry ^ fa_cout;
                        zero_r  <= (next_res == '0);
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = (state == ST_DONE);
    assign bus.result   = res_sh;
    assign bus.c_out    = c_out_r;
    assign bus.overflow = ovf_r;
    assign bus.zero     = zero_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: arithmetic vectors, ignored starts and mid-operation reset.
module tb_serial_addsub;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one start pulse; returns in cycle k+1 with operands scrambled so re-sampling would show.
    task automatic apply_stimulus(input logic sub, input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        @(negedge clk);
        bus.op_sub = sub;
        bus.a      = op_a;
        bus.b      = op_b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.op_sub = ~sub;
        bus.a      = ~op_a;
        bus.b      = ~op_b;
    endtask

    task automatic check_output(input string tag, input logic [WIDTH-1:0] exp_res,
                                input logic exp_c, input logic exp_v, input logic exp_z);
        for (int i = 0; i < WIDTH; i++) begin
            check_bit($sformatf("%s busy[%0d]", tag, i + 1), bus.busy, 1'b1);
            check_bit($sformatf("%s done[%0d]", tag, i + 1), bus.done, 1'b0);
            if (i == 0) begin
                check_bit({tag, " c_out cleared"}, bus.c_out, 1'b0);
                check_bit({tag, " zero cleared"}, bus.zero, 1'b0);
            end
            @(negedge clk);
        end
        check_bit({tag, " done"}, bus.done, 1'b1);
        check_bit({tag, " busy@done"}, bus.busy, 1'b0);
        check_word({tag, " result"}, bus.result, exp_res);
        check_bit({tag, " c_out"}, bus.c_out, exp_c);
        check_bit({tag, " overflow"}, bus.overflow, exp_v);
        check_bit({tag, " zero"}, bus.zero, exp_z);
        @(negedge clk);
        check_bit({tag, " done pulse ends"}, bus.done, 1'b0);
        check_word({tag, " result held"}, bus.result, exp_res);
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(negedge clk);
        check_bit("reset busy", bus.busy, 1'b0);
        check_bit("reset done", bus.done, 1'b0);
        check_word("reset result", bus.result, 8'h00);
        check_bit("reset c_out", bus.c_out, 1'b0);
        check_bit("reset overflow", bus.overflow, 1'b0);
        check_bit("reset zero", bus.zero, 1'b0);
        rst = 1'b0;

        $display("[TB] arithmetic vectors");
        apply_stimulus(1'b0, 8'h3C, 8'h0F);
        check_output("add 3C+0F", 8'h4B, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'hFF, 8'h01);
        check_output("add FF+01", 8'h00, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'h7F, 8'h01);
        check_output("add 7F+01", 8'h80, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h80, 8'h01);
        check_output("sub 80-01", 8'h7F, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h05, 8'h07);
        check_output("sub 05-07", 8'hFE, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h09, 8'h09);
        check_output("sub 09-09", 8'h00, 1'b1, 1'b0, 1'b1);

        $display("[TB] start pulses while busy and done");
        apply_stimulus(1'b0, 8'h10, 8'h20);
        for (int c = 1; c <= WIDTH; c++) begin
            check_bit($sformatf("ign busy[%0d]", c), bus.busy, 1'b1);
            check_bit($sformatf("ign done[%0d]", c), bus.done, 1'b0);
            if (c == 3) begin
                bus.start  = 1'b1;
                bus.op_sub = 1'b1;
                bus.a      = 8'hAA;
                bus.b      = 8'h55;
            end
            if (c == 4) bus.start = 1'b0;
            @(negedge clk);
        end
        check_bit("ign done", bus.done, 1'b1);
        check_word("ign result", bus.result, 8'h30);
        check_bit("ign c_out", bus.c_out, 1'b0);
        check_bit("ign overflow", bus.overflow, 1'b0);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        check_bit("ign idle busy", bus.busy, 1'b0);
        check_bit("ign idle done", bus.done, 1'b0);
        check_word("ign idle result", bus.result, 8'h30);
        @(negedge clk);
        check_bit("ign not accepted", bus.busy, 1'b0);
        check_word("ign result still held", bus.result, 8'h30);

        $display("[TB] reset mid-operation");
        apply_stimulus(1'b0, 8'h5A, 8'h11);
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check_bit("rst busy", bus.busy, 1'b0);
        check_bit("rst done", bus.done, 1'b0);
        check_word("rst result", bus.result, 8'h00);
        check_bit("rst c_out", bus.c_out, 1'b0);
        check_bit("rst overflow", bus.overflow, 1'b0);
        check_bit("rst zero", bus.zero, 1'b0);
        for (int c = 0; c < WIDTH + 2; c++) begin
            @(negedge clk);
            check_bit($sformatf("rst no done[%0d]", c), bus.done, 1'b0);
            check_bit($sformatf("rst stays idle[%0d]", c), bus.busy, 1'b0);
        end
        apply_stimulus(1'b0, 8'h5A, 8'h11);
        check_output("add 5A+11 after rst", 8'h6B, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
